// File: rtl/rand_range_gen.sv
// Galois LFSR random source with runtime seeding and a request/valid port that
// reduces an LFSR sample into [0, range) with a bit-serial restoring remainder.
module rand_range_gen #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
  parameter int               OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed,
  input  logic                 req,
  input  logic [OUT_WIDTH-1:0] range,
  output logic                 busy,
  output logic                 valid,
  output logic [OUT_WIDTH-1:0] random_number,
  output logic [WIDTH-1:0]     raw
);

  localparam int CNT_W = $clog2(OUT_WIDTH + 1);

  typedef enum logic {IDLE, DIV} state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     lfsr_q, lfsr_d;
  logic [OUT_WIDTH-1:0] sample_q, div_q, rem_q, rem_d, rn_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 valid_q;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The partial remainder needs one extra bit before the compare.
  function automatic logic [OUT_WIDTH-1:0] rem_step(input logic [OUT_WIDTH-1:0] rem,
                                                    input logic                 b,
                                                    input logic [OUT_WIDTH-1:0] d);
    logic [OUT_WIDTH:0] sh;
    sh = {rem, b};
    if (sh >= {1'b0, d}) sh = sh - {1'b0, d};
    return sh[OUT_WIDTH-1:0];
  endfunction

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
    if (seed_load) lfsr_d = (seed == '0) ? SEED : seed;
  end

  assign rem_d = rem_step(rem_q, sample_q[OUT_WIDTH-1], div_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      rn_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (range == '0) begin
              rn_q    <= lfsr_q[OUT_WIDTH-1:0];
              valid_q <= 1'b1;
            end else begin
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          if (cnt_q == '0) begin
            rn_q    <= rem_d;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operands are captured on acceptance so input changes mid-division are harmless.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) begin
      sample_q <= lfsr_q[OUT_WIDTH-1:0];
      div_q    <= range;
      rem_q    <= '0;
      cnt_q    <= CNT_W'(OUT_WIDTH - 1);
    end else if (state_q == DIV) begin
      sample_q <= sample_q << 1;
      rem_q    <= rem_d;
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

  assign busy          = (state_q == DIV);
  assign valid         = valid_q;
  assign random_number = rn_q;
  assign raw           = lfsr_q;

endmodule

// File: tb/tb_rand_range_gen.sv
// Bench for rand_range_gen: cycle-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed results and a 4-bit period check.
module tb_rand_range_gen;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk;
  logic        reset;
  logic        seed_load;
  logic [15:0] seed;
  logic        req;
  logic [7:0]  rng;
  logic        busy, valid;
  logic [7:0]  random_number;
  logic [15:0] raw;

  logic       r4_reset;
  logic       r4_busy, r4_valid;
  logic [3:0] r4_rn, r4_raw;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  rand_range_gen dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed),
    .req(req), .range(rng), .busy(busy), .valid(valid),
    .random_number(random_number), .raw(raw)
  );

  rand_range_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_WIDTH(4)) u4 (
    .clk(clk), .reset(r4_reset), .seed_load(1'b0), .seed(4'h0),
    .req(1'b0), .range(4'h0), .busy(r4_busy), .valid(r4_valid),
    .random_number(r4_rn), .raw(r4_raw)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: counts busy cycles and holds the precomputed modulo.
  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  logic [15:0] m_lfsr;
  int          m_left;
  logic        m_valid;
  logic [7:0]  m_rn, m_pend;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr  <= SEED;
      m_left  <= 0;
      m_valid <= 0;
      m_rn    <= 0;
    end else begin
      m_lfsr  <= seed_load ? ((seed == 0) ? SEED : seed) : step(m_lfsr);
      m_valid <= 0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_valid <= 1;
          m_rn    <= m_pend;
        end
      end else if (req) begin
        if (rng == 0) begin
          m_valid <= 1;
          m_rn    <= m_lfsr[7:0];
        end else begin
          m_pend <= m_lfsr[7:0] % rng;
          m_left <= 8;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("raw", raw, m_lfsr);
      chk("busy", busy, m_left != 0);
      chk("valid", valid, m_valid);
      chk("random_number", random_number, m_rn);
    end
  end

  task automatic seed_req(input logic [15:0] s, input logic [7:0] r, output logic [7:0] res,
                          output int bcnt, output int vcnt, output bit v_first);
    @(negedge clk); seed_load = 1; seed = s;
    @(negedge clk); seed_load = 0; req = 1; rng = r;
    @(negedge clk); req = 0;
    v_first = valid; bcnt = 0; vcnt = 0; res = random_number;
    for (int k = 0; k < 12; k++) begin
      if (busy) bcnt++;
      if (valid) begin vcnt++; res = random_number; end
      @(negedge clk);
    end
  endtask

  logic [7:0] res;
  int         bcnt, vcnt;
  bit         vf;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; r4_reset = 1; seed_load = 0; seed = 0; req = 0; rng = 0;
    #1; reset = 0; r4_reset = 0;
    #1; chk_en = 1;

    // Reset state and first step
    @(negedge clk); @(negedge clk);
    chk("rst_raw", raw, 16'hACE1);
    chk("rst_rn", random_number, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1;
    @(posedge clk); #2;
    chk("first_step", raw, 16'hE270);
    chk("model_first_step", m_lfsr, 16'hE270);

    // Seeded ranged request: 200 mod 7
    seed_req(16'h00C8, 8'd7, res, bcnt, vcnt, vf);
    chk("mod7_result", res, 8'd4);
    chk("mod7_busy_cycles", bcnt, 8);
    chk("mod7_valid_count", vcnt, 1);

    // Bypass with range 0
    seed_req(16'h00C8, 8'd0, res, bcnt, vcnt, vf);
    chk("bypass_result", res, 8'hC8);
    chk("bypass_valid_first", vf, 1'b1);
    chk("bypass_busy_cycles", bcnt, 0);
    chk("bypass_valid_count", vcnt, 1);

    seed_req(16'h00C8, 8'd1, res, bcnt, vcnt, vf);
    chk("range1_result", res, 8'd0);
    seed_req(16'h00FF, 8'd255, res, bcnt, vcnt, vf);
    chk("range255_result", res, 8'd0);
    seed_req(16'h1234, 8'd10, res, bcnt, vcnt, vf);
    chk("mod10_result", res, 8'd2);

    // Zero seed falls back to SEED
    @(negedge clk); seed_load = 1; seed = 16'h0000;
    @(negedge clk); seed_load = 0;
    chk("zero_seed_raw", raw, 16'hACE1);

    // Requests while busy are dropped
    vcnt = 0;
    @(negedge clk); req = 1; rng = 8'd7;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 3) req = 0;
      if (valid) vcnt++;
    end
    chk("dropped_req_valid_count", vcnt, 1);

    // Mid-operation reset
    @(negedge clk); req = 1; rng = 8'd7;
    @(negedge clk); req = 0;
    @(negedge clk); @(negedge clk);
    chk("pre_abort_busy", busy, 1'b1);
    reset = 0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", valid, 1'b0);
    chk("abort_raw", raw, 16'hACE1);
    @(negedge clk); @(negedge clk); reset = 1;
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    chk("abort_no_valid", vcnt, 0);

    // 4-bit period
    begin
      bit seen[16];
      int first_ret, distinct;
      first_ret = 0; distinct = 0;
      for (int i = 0; i < 16; i++) seen[i] = 0;
      @(negedge clk); r4_reset = 1;
      for (int i = 1; i <= 15; i++) begin
        @(posedge clk); #2;
        if (r4_raw == 4'h1 && first_ret == 0) first_ret = i;
        if (r4_raw != 0 && !seen[r4_raw]) begin seen[r4_raw] = 1; distinct++; end
      end
      chk("period4_return", first_ret, 15);
      chk("period4_distinct", distinct, 15);
    end

    // Random requests: result always below range
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] r;
      bit got;
      r = 8'($urandom_range(1, 255));
      @(negedge clk); req = 1; rng = r;
      if ($urandom_range(0, 3) == 0) begin seed_load = 1; seed = 16'($urandom); end
      @(negedge clk); req = 0; seed_load = 0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        if (valid) begin
          got = 1;
          checks++;
          if (!(random_number < r)) begin
            errors++;
            $display("FAIL rand_below_range: got %0d expected < %0d", random_number, r);
          end
        end else begin
          @(negedge clk);
        end
      end
      if (!got) chk("rand_valid_timeout", 0, 1);
    end

    chk_en = 0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
